// File: rtl/pres_ctrl_pkg.sv
// Shared types and defaults for the PRESENT-80 round controller.
package pres_ctrl_pkg;

  localparam int NUM_ROUNDS_DEF = 31;
  localparam int RC_W_DEF       = 5;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    ROUND = 3'd2,
    FINAL = 3'd3,
    HOLD  = 3'd4
  } state_e;

  typedef logic [RC_W_DEF-1:0] round_cnt_t;

endpackage

// File: rtl/pres_round_counter.sv
// Loadable up/down round counter; load has priority over count enable.
module pres_round_counter #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         srst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  input  logic         dir,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q, cnt_d;

  // dir = 1 counts down (inverse key schedule order)
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (en) begin
      cnt_d = dir ? (cnt_q - W'(1)) : (cnt_q + W'(1));
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/present_round_ctrl.sv
// FSM sequencer for the iterative PRESENT-80 datapath (Moore outputs).
// Optional decryption support is enabled with `define PRES_DEC_EN.
module present_round_ctrl
  import pres_ctrl_pkg::*;
#(
  parameter int NUM_ROUNDS = NUM_ROUNDS_DEF,
  parameter int RC_W       = RC_W_DEF
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            start,
  output logic            busy,
  output logic            sel,
  output logic            load_en,
  output logic            round_en,
  output logic [RC_W-1:0] round_cnt,
  output logic            last_round,
  output logic            final_en,
  output logic            dout_valid,
  input  logic            dout_ack
`ifdef PRES_DEC_EN
  ,
  input  logic            dec,
  output logic            key_dir
`endif
);

  localparam logic [RC_W-1:0] CNT_LO = RC_W'(1);
  localparam logic [RC_W-1:0] CNT_HI = RC_W'(NUM_ROUNDS);

  state_e          state_q, state_d;
  logic            down;
  logic            accept_start;
  logic            cnt_load, cnt_en;
  logic [RC_W-1:0] cnt_val;
  logic [RC_W-1:0] first_cnt, final_cnt;

  assign accept_start = start && ((state_q == IDLE) || ((state_q == HOLD) && dout_ack));

`ifdef PRES_DEC_EN
  logic dec_q, dec_d;

  // Direction is frozen at the start edge for the whole block
  always_comb begin
    dec_d = dec_q;
    if (accept_start) dec_d = dec;
  end

  always_ff @(posedge CLK) begin
    if (RST) dec_q <= 1'b0;
    else     dec_q <= dec_d;
  end

  assign down    = dec_q;
  assign key_dir = dec_q;
`else
  assign down = 1'b0;
`endif

  assign first_cnt = down ? CNT_HI : CNT_LO;
  assign final_cnt = down ? CNT_LO : CNT_HI;

  always_comb begin
    state_d    = state_q;
    cnt_load   = 1'b0;
    cnt_val    = '0;
    cnt_en     = 1'b0;
    busy       = 1'b0;
    sel        = 1'b0;
    load_en    = 1'b0;
    round_en   = 1'b0;
    last_round = 1'b0;
    final_en   = 1'b0;
    dout_valid = 1'b0;
    unique case (state_q)
      IDLE: begin
        cnt_load = 1'b1;
        if (accept_start) state_d = LOAD;
      end
      LOAD: begin
        busy     = 1'b1;
        load_en  = 1'b1;
        cnt_load = 1'b1;
        cnt_val  = first_cnt;
        state_d  = ROUND;
      end
      ROUND: begin
        busy     = 1'b1;
        sel      = 1'b1;
        round_en = 1'b1;
        // Counter parks on the final value so it never wraps past it
        if (round_cnt == final_cnt) begin
          last_round = 1'b1;
          state_d    = FINAL;
        end else begin
          cnt_en = 1'b1;
        end
      end
      FINAL: begin
        busy     = 1'b1;
        sel      = 1'b1;
        final_en = 1'b1;
        cnt_load = 1'b1;
        state_d  = HOLD;
      end
      HOLD: begin
        busy       = 1'b1;
        dout_valid = 1'b1;
        cnt_load   = 1'b1;
        if (dout_ack) state_d = accept_start ? LOAD : IDLE;
      end
      default: begin
        cnt_load = 1'b1;
        state_d  = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) state_q <= IDLE;
    else     state_q <= state_d;
  end

  pres_round_counter #(
    .W(RC_W)
  ) u_cnt (
    .clk      (CLK),
    .srst     (RST),
    .load     (cnt_load),
    .load_val (cnt_val),
    .en       (cnt_en),
    .dir      (down),
    .cnt      (round_cnt)
  );

endmodule

// File: tb/tb_present_round_ctrl.sv
// Self-checking bench for present_round_ctrl: vector table, directed sequences, random run vs. timeline model.
module tb_present_round_ctrl;
  import pres_ctrl_pkg::*;

  localparam int N = NUM_ROUNDS_DEF;
  localparam int W = RC_W_DEF;
`ifdef PRES_DEC_EN
  localparam bit DEC_BUILD = 1'b1;
`else
  localparam bit DEC_BUILD = 1'b0;
`endif

  logic         CLK = 1'b0;
  logic         RST, start, dout_ack, dec_drv;
  logic         busy, sel, load_en, round_en, last_round, final_en, dout_valid;
  logic [W-1:0] round_cnt;
`ifdef PRES_DEC_EN
  logic         key_dir;
`endif

  int checks = 0;
  int errors = 0;

  // Model: m_t = cycles since the LOAD cycle of the current block, -1 when idle
  int m_t   = -1;
  bit m_dec = 1'b0;

  always #5 CLK = ~CLK;

  present_round_ctrl #(.NUM_ROUNDS(N), .RC_W(W)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .start      (start),
    .busy       (busy),
    .sel        (sel),
    .load_en    (load_en),
    .round_en   (round_en),
    .round_cnt  (round_cnt),
    .last_round (last_round),
    .final_en   (final_en),
    .dout_valid (dout_valid),
    .dout_ack   (dout_ack)
`ifdef PRES_DEC_EN
    ,
    .dec        (dec_drv),
    .key_dir    (key_dir)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  function automatic void model_step(input bit r, input bit s, input bit a, input bit d);
    if (r) begin
      m_t   = -1;
      m_dec = 1'b0;
    end else if (m_t < 0) begin
      if (s) begin m_t = 0; m_dec = DEC_BUILD & d; end
    end else if (m_t < N + 2) begin
      m_t++;
    end else if (a) begin
      if (s) begin m_t = 0; m_dec = DEC_BUILD & d; end
      else   m_t = -1;
    end
  endfunction

  task automatic compare_model();
    bit in_round = (m_t >= 1) && (m_t <= N);
    int exp_cnt  = in_round ? (m_dec ? (N + 1 - m_t) : m_t) : 0;
    check("busy",       busy,       m_t >= 0);
    check("sel",        sel,        (m_t >= 1) && (m_t <= N + 1));
    check("load_en",    load_en,    m_t == 0);
    check("round_en",   round_en,   in_round);
    check("last_round", last_round, m_t == N);
    check("final_en",   final_en,   m_t == N + 1);
    check("dout_valid", dout_valid, m_t >= N + 2);
    if (m_t != N + 1) check("round_cnt", round_cnt, exp_cnt);
`ifdef PRES_DEC_EN
    check("key_dir", key_dir, m_dec);
`endif
  endtask

  // Drive one cycle's inputs, pass the rising edge, compare on the falling edge
  task automatic cycle(input bit r, input bit s, input bit a, input bit d);
    RST = r; start = s; dout_ack = a; dec_drv = d;
    model_step(r, s, a, d);
    @(negedge CLK);
    compare_model();
  endtask

  // Run with start held at s until dout_valid; counts what was seen on the way
  task automatic run_to_valid(input bit s, input bit d, output int lat,
                              output int loads, output int rounds, output int lasts);
    lat = 0; loads = 0; rounds = 0; lasts = 0;
    for (int k = 0; k < 3 * N; k++) begin
      if (dout_valid) break;
      cycle(1'b0, s, 1'b0, d);
      lat++;
      loads  += int'(load_en);
      rounds += int'(round_en);
      lasts  += int'(last_round);
    end
    if (!dout_valid) check("valid_timeout", 0, 1);
  endtask

  typedef struct packed {
    bit          rst;
    bit          st;
    bit          ack;
    logic [11:0] exp; // {busy,sel,load_en,round_en,last_round,final_en,dout_valid,round_cnt}
  } vec_t;

  vec_t vecs[9];

  initial begin
    int lat, loads, rounds, lasts;
    logic [11:0] got;
    bit d;

    vecs[0] = '{1'b1, 1'b0, 1'b0, 12'b0000000_00000};
    vecs[1] = '{1'b1, 1'b1, 1'b1, 12'b0000000_00000};
    vecs[2] = '{1'b1, 1'b0, 1'b0, 12'b0000000_00000};
    vecs[3] = '{1'b0, 1'b0, 1'b1, 12'b0000000_00000};
    vecs[4] = '{1'b0, 1'b1, 1'b0, 12'b1010000_00000};
    vecs[5] = '{1'b0, 1'b1, 1'b0, 12'b1101000_00001};
    vecs[6] = '{1'b0, 1'b0, 1'b1, 12'b1101000_00010};
    vecs[7] = '{1'b1, 1'b1, 1'b0, 12'b0000000_00000};
    vecs[8] = '{1'b0, 1'b0, 1'b0, 12'b0000000_00000};

    for (int i = 0; i < 9; i++) begin
      cycle(vecs[i].rst, vecs[i].st, vecs[i].ack, 1'b0);
      got = {busy, sel, load_en, round_en, last_round, final_en, dout_valid, round_cnt};
      check($sformatf("vec%0d", i), got, vecs[i].exp);
    end

    // Single block: latency, round count, one last_round
    cycle(1'b0, 1'b1, 1'b0, 1'b0);
    check("single_load", load_en, 1);
    run_to_valid(1'b0, 1'b0, lat, loads, rounds, lasts);
    check("single_latency", lat, N + 2);
    check("single_rounds", rounds, N);
    check("single_lasts", lasts, 1);
    for (int k = 0; k < 4; k++) cycle(1'b0, 1'b1, 1'b0, 1'b0);
    check("hold_keeps_valid", dout_valid, 1);
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    check("ack_to_idle", busy, 0);

    // start held through a block, then back-to-back via ack+start
    cycle(1'b0, 1'b1, 1'b0, 1'b0);
    run_to_valid(1'b1, 1'b0, lat, loads, rounds, lasts);
    check("held_extra_loads", loads, 0);
    check("held_rounds", rounds, N);
    cycle(1'b0, 1'b1, 1'b1, 1'b0);
    check("b2b_load_en", load_en, 1);
    check("b2b_valid", dout_valid, 0);
    run_to_valid(1'b0, 1'b0, lat, loads, rounds, lasts);
    check("b2b_latency", lat, N + 2);
    check("b2b_rounds", rounds, N);
    cycle(1'b0, 1'b0, 1'b1, 1'b0);

    // Reset in the middle of a block at round_cnt = 15
    cycle(1'b0, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 2 * N; k++) begin
      if (round_cnt == W'(15)) break;
      cycle(1'b0, 1'b0, 1'b0, 1'b0);
    end
    check("reach_cnt15", round_cnt, 15);
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    check("midrst_busy", busy, 0);
    check("midrst_cnt", round_cnt, 0);
    cycle(1'b0, 1'b1, 1'b0, 1'b0);
    run_to_valid(1'b0, 1'b0, lat, loads, rounds, lasts);
    check("after_rst_rounds", rounds, N);
    cycle(1'b0, 1'b0, 1'b1, 1'b0);

`ifdef PRES_DEC_EN
    // Decrypt: dec toggles after the start edge but direction stays latched
    cycle(1'b0, 1'b1, 1'b0, 1'b1);
    d = 1'b0;
    run_to_valid(1'b0, d, lat, loads, rounds, lasts);
    check("dec_key_dir", key_dir, 1);
    check("dec_latency", lat, N + 2);
    check("dec_lasts", lasts, 1);
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
`endif

    // Random traffic against the timeline model
    for (int k = 0; k < 3000; k++) begin
      d = 1'($urandom_range(0, 1));
      cycle(($urandom_range(0, 199) == 0), ($urandom_range(0, 9) < 3),
            ($urandom_range(0, 9) < 2), d);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
